i2s_dac_serializer: RTL and testbench
=====================================

// Module: i2s_dac_serializer
// PURPOSE
//  Downstream of the BCLK/LRC generator: consumes its bclk/lrc strobes (registered in clk50) and shifts
//  stereo PCM words onto the WM8731 DACDAT pin in I2S format. Samples come from the WAV decoder via a
//  valid/ready handshake and are held in a one-deep stereo buffer. Underruns are flagged and counted.
// PARAMETERS
//  DATA_W  16  bits per channel, MSB first; legal 8..30 (DATA_W+1 must fit in 31 bclk per lrc half)
//  UNDR_W   8  width of saturating underrun counter
// PORTS
//  clk50          in   1        system clock (50 MHz); all logic on posedge
//  rst_n          in   1        asynchronous, active-low reset
//  bclk           in   1        bit clock from generator, synchronous to clk50
//  lrc            in   1        L/R clock from generator; 0 = left, 1 = right
//  sample_l       in   DATA_W   left PCM word (two's complement)
//  sample_r       in   DATA_W   right PCM word
//  sample_valid   in   1        upstream has a stereo pair
//  sample_ready   out  1        buffer empty; pair accepted when valid&ready at clk50 edge
//  dacdat         out  1        serial data to codec, changes after bclk falling edges
//  underrun       out  1        one-cycle pulse: left frame started with buffer empty
//  underrun_cnt   out  UNDR_W   saturating count of underruns
// BEHAVIOUR
//  Reset: dacdat=0, sample_ready=1, underrun=0, underrun_cnt=0, buffer empty, bclk_d/lrc_d=0, state=WAIT.
//  Edge detect: bclk_fall = bclk_d & ~bclk; lrc_fall = lrc_d & ~lrc; lrc_rise = ~lrc_d & lrc.
//  Buffer: pend_l/pend_r + pend_full; sample_ready = ~pend_full. Accept on valid&ready.
//  Frame load on lrc_fall: if pend_full, act_l<=pend_l, act_r<=pend_r, pend_full cleared; else act_l/act_r<=0,
//   underrun pulses next cycle, underrun_cnt+1 (holds at all-ones).
//  Same-cycle accept and lrc_fall with pend_full=1: impossible (ready=0). With pend_full=0: no underrun is
//   NOT excused — counts as underrun, act<=0, and the new pair lands in pend_full (used next frame).
//  FSM (one channel at a time):
//   WAIT  : after reset; ignore lrc_rise; on lrc_fall -> frame load, DELAY(left).
//   DELAY : on bclk_fall drive dacdat=0 (I2S one-bit delay slot) -> SHIFT, bitcnt=DATA_W-1.
//   SHIFT : on bclk_fall drive dacdat=word[bitcnt]; at bitcnt==0 -> PAD, else bitcnt-1.
//   PAD   : on bclk_fall drive dacdat=0; hold until next lrc edge.
//   Any state except WAIT: lrc_rise -> DELAY(right, word=act_r); lrc_fall -> frame load, DELAY(left).
//  MSB is driven on the 2nd bclk falling edge after an lrc edge; LSB on the (DATA_W+1)th; then 0.
//  dacdat is a register updated in the clk50 cycle where bclk_fall is detected (1 cycle after bclk drops).
//  lrc edge and bclk_fall in same cycle: lrc edge wins; that bclk_fall is not the delay slot, dacdat<=0.
//  lrc edge while SHIFT unfinished: abort remaining bits, start new channel (no error flag).
//  Mid-operation reset: all state cleared asynchronously; buffered pair discarded; back to WAIT.
// TESTING
//  1 reset, load L=16'hA5C3 R=16'h0F0F before first lrc fall -> after lrc fall: fall#1 0, falls#2..17
//    = A5C3 MSB first, then 0; after lrc rise same for 0F0F; ready=1 cycle after lrc fall.
//  2 no sample ever loaded -> dacdat stays 0, underrun pulses 1 cycle at each lrc fall, cnt 1,2,3...
//  3 valid held high with pairs P1,P2 -> P1 accepted, ready=0 until next lrc fall, P2 accepted cycle after;
//    P1 serialized in frame N, P2 in frame N+1.
//  4 valid first asserted in exact lrc_fall cycle -> underrun=1, frame all zeros, pair sent next frame.
//  5 assert rst_n=0 during left SHIFT bit 7 -> dacdat=0, ready=1, cnt=0 immediately; after release first
//    lrc rise ignored, serialization resumes at next lrc fall.
//  6 force 300 underruns with UNDR_W=8 -> underrun_cnt holds 8'hFF; pulses continue.

Source files
------------

// File: rtl/i2s_dac_serializer.sv
// i2s_dac_serializer
// Takes stereo PCM pairs over a valid/ready handshake into a one-deep buffer
// and shifts them MSB-first onto the codec DACDAT pin in I2S framing. The
// bit and L/R clocks arrive as clk50-synchronous levels and are edge-detected
// here. A left frame that starts with no pair buffered sends silence and is
// flagged and counted as an underrun.
module i2s_dac_serializer #(
    parameter int DATA_W = 16,
    parameter int UNDR_W = 8
) (
    input  logic              clk50,
    input  logic              rst_n,
    input  logic              bclk,
    input  logic              lrc,
    input  logic [DATA_W-1:0] sample_l,
    input  logic [DATA_W-1:0] sample_r,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              dacdat,
    output logic              underrun,
    output logic [UNDR_W-1:0] underrun_cnt
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] BIT_TOP = CNT_W'(DATA_W - 1);

    localparam logic [1:0] ST_WAIT  = 2'd0;
    localparam logic [1:0] ST_DELAY = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_PAD   = 2'd3;

    logic              bclk_dly_q, bclk_dly_d;
    logic              lrc_dly_q, lrc_dly_d;
    logic [DATA_W-1:0] pend_l_q, pend_l_d;
    logic [DATA_W-1:0] pend_r_q, pend_r_d;
    logic              pend_full_q, pend_full_d;
    logic [DATA_W-1:0] act_l_q, act_l_d;
    logic [DATA_W-1:0] act_r_q, act_r_d;
    logic [1:0]        state_q, state_d;
    logic              chan_q, chan_d;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic              dacdat_q, dacdat_d;
    logic              underrun_q, underrun_d;
    logic [UNDR_W-1:0] underrun_cnt_q, underrun_cnt_d;

    logic              bclk_fall;
    logic              lrc_fall;
    logic              lrc_rise;
    logic              accept;
    logic              starve;
    logic [DATA_W-1:0] cur_word;

    assign bclk_fall = bclk_dly_q & ~bclk;
    assign lrc_fall  = lrc_dly_q & ~lrc;
    assign lrc_rise  = ~lrc_dly_q & lrc;
    assign accept    = sample_valid & ~pend_full_q;
    assign starve    = lrc_fall & ~pend_full_q;
    assign cur_word  = chan_q ? act_r_q : act_l_q;

    assign sample_ready = ~pend_full_q;
    assign dacdat       = dacdat_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = underrun_cnt_q;

    // Input buffer, frame load and underrun bookkeeping.
    always_comb begin
        bclk_dly_d     = bclk;
        lrc_dly_d      = lrc;
        pend_l_d       = pend_l_q;
        pend_r_d       = pend_r_q;
        pend_full_d    = pend_full_q;
        act_l_d        = act_l_q;
        act_r_d        = act_r_q;
        underrun_d     = starve;
        underrun_cnt_d = underrun_cnt_q;

        // A frame start drains the buffer; with an empty buffer it sends silence.
        if (lrc_fall) begin
            act_l_d     = pend_full_q ? pend_l_q : '0;
            act_r_d     = pend_full_q ? pend_r_q : '0;
            pend_full_d = 1'b0;
        end
        // Accept only happens with the buffer empty, so a pair arriving in the
        // frame-start cycle lands here for the following frame.
        if (accept) begin
            pend_l_d    = sample_l;
            pend_r_d    = sample_r;
            pend_full_d = 1'b1;
        end
        if (starve && (underrun_cnt_q != '1)) begin
            underrun_cnt_d = underrun_cnt_q + UNDR_W'(1);
        end
    end

    // Channel sequencer: delay slot, MSB-first shift, then zero padding.
    always_comb begin
        state_d  = state_q;
        chan_d   = chan_q;
        bitcnt_d = bitcnt_q;
        dacdat_d = dacdat_q;

        if (lrc_fall) begin
            state_d = ST_DELAY;
            chan_d  = 1'b0;
            if (bclk_fall) dacdat_d = 1'b0;
        end else if (lrc_rise && (state_q != ST_WAIT)) begin
            state_d = ST_DELAY;
            chan_d  = 1'b1;
            if (bclk_fall) dacdat_d = 1'b0;
        end else if (bclk_fall) begin
            case (state_q)
                ST_DELAY: begin
                    dacdat_d = 1'b0;
                    state_d  = ST_SHIFT;
                    bitcnt_d = BIT_TOP;
                end
                ST_SHIFT: begin
                    dacdat_d = cur_word[bitcnt_q];
                    if (bitcnt_q == '0) state_d = ST_PAD;
                    else                bitcnt_d = bitcnt_q - CNT_W'(1);
                end
                ST_PAD: begin
                    dacdat_d = 1'b0;
                end
                default: begin
                    state_d = ST_WAIT;
                end
            endcase
        end
    end

    // State registers; reset discards any buffered pair and returns to WAIT.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            bclk_dly_q     <= 1'b0;
            lrc_dly_q      <= 1'b0;
            pend_l_q       <= '0;
            pend_r_q       <= '0;
            pend_full_q    <= 1'b0;
            act_l_q        <= '0;
            act_r_q        <= '0;
            state_q        <= ST_WAIT;
            chan_q         <= 1'b0;
            bitcnt_q       <= '0;
            dacdat_q       <= 1'b0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            bclk_dly_q     <= bclk_dly_d;
            lrc_dly_q      <= lrc_dly_d;
            pend_l_q       <= pend_l_d;
            pend_r_q       <= pend_r_d;
            pend_full_q    <= pend_full_d;
            act_l_q        <= act_l_d;
            act_r_q        <= act_r_d;
            state_q        <= state_d;
            chan_q         <= chan_d;
            bitcnt_q       <= bitcnt_d;
            dacdat_q       <= dacdat_d;
            underrun_q     <= underrun_d;
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// Testbench for i2s_dac_serializer: drives bclk/lrc itself, feeds pairs from
// a queue and compares every cycle against a frame-level model that counts
// bclk falls since the last lrc edge.
module tb_i2s_dac_serializer;

    localparam int DATA_W  = 16;
    localparam int UNDR_W  = 8;
    localparam int CNT_MAX = (1 << UNDR_W) - 1;

    typedef struct packed {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
    } pair_t;

    logic              clk50 = 1'b0;
    logic              rst_n = 1'b1;
    logic              bclk  = 1'b0;
    logic              lrc   = 1'b0;
    logic [DATA_W-1:0] sample_l = '0;
    logic [DATA_W-1:0] sample_r = '0;
    logic              sample_valid = 1'b0;
    logic              sample_ready;
    logic              dacdat;
    logic              underrun;
    logic [UNDR_W-1:0] underrun_cnt;

    int checks   = 0;
    int failures = 0;

    // model state
    bit                m_pend_full;
    logic [DATA_W-1:0] m_pend_l, m_pend_r, m_act_l, m_act_r;
    bit                m_started, m_chan, m_dac, m_undr, m_bit_new;
    int                m_k, m_cnt;
    bit                prev_bclk, prev_lrc;
    logic [DATA_W-1:0] cap_l, cap_r;

    // stimulus state
    pair_t src_q[$];
    bit    drv_valid  = 1'b0;
    bit    drv_rst_n  = 1'b0;
    bit    rand_prod  = 1'b0;
    bit    inject_pending = 1'b0;
    pair_t inject_pair;

    i2s_dac_serializer #(.DATA_W(DATA_W), .UNDR_W(UNDR_W)) dut (
        .clk50       (clk50),
        .rst_n       (rst_n),
        .bclk        (bclk),
        .lrc         (lrc),
        .sample_l    (sample_l),
        .sample_r    (sample_r),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .dacdat      (dacdat),
        .underrun    (underrun),
        .underrun_cnt(underrun_cnt)
    );

    always #10 clk50 = ~clk50;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend_full = 1'b0;
        m_pend_l = '0; m_pend_r = '0; m_act_l = '0; m_act_r = '0;
        m_started = 1'b0; m_chan = 1'b0; m_k = 0;
        m_dac = 1'b0; m_undr = 1'b0; m_bit_new = 1'b0; m_cnt = 0;
        prev_bclk = 1'b0; prev_lrc = 1'b0;
        drv_valid = 1'b0;
        src_q.delete();
    endtask

    // One clk50 cycle: check last posedge's outputs, drive, predict next posedge.
    task automatic step(input bit b, input bit l);
        bit fall, lf, lr, acc;
        logic [DATA_W-1:0] word;
        @(negedge clk50);
        check_val("dacdat",   32'(dacdat),       32'(m_dac));
        check_val("ready",    32'(sample_ready), 32'(!m_pend_full));
        check_val("underrun", 32'(underrun),     32'(m_undr));
        check_val("cnt",      32'(underrun_cnt), 32'(m_cnt));
        if (m_bit_new) begin
            if (m_chan) cap_r = {cap_r[DATA_W-2:0], dacdat};
            else        cap_l = {cap_l[DATA_W-2:0], dacdat};
        end

        if (rand_prod && src_q.size() == 0 && $urandom_range(0, 15) == 0)
            src_q.push_back(pair_t'({16'($urandom), 16'($urandom)}));
        if (!drv_valid && src_q.size() > 0) begin
            drv_valid = 1'b1;
            sample_l  = src_q[0].l;
            sample_r  = src_q[0].r;
        end
        rst_n        = drv_rst_n;
        bclk         = b;
        lrc          = l;
        sample_valid = drv_valid;

        if (!drv_rst_n) begin
            model_reset();
        end else begin
            fall = prev_bclk && !b;
            lf   = prev_lrc && !l;
            lr   = !prev_lrc && l;
            acc  = drv_valid && !m_pend_full;
            m_undr    = 1'b0;
            m_bit_new = 1'b0;
            if (lf) begin
                m_started = 1'b1; m_chan = 1'b0; m_k = 0;
                if (m_pend_full) begin
                    m_act_l = m_pend_l; m_act_r = m_pend_r; m_pend_full = 1'b0;
                end else begin
                    m_act_l = '0; m_act_r = '0; m_undr = 1'b1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                end
            end
            if (acc) begin
                m_pend_l = sample_l; m_pend_r = sample_r; m_pend_full = 1'b1;
                void'(src_q.pop_front());
                drv_valid = 1'b0;
            end
            if (lr && m_started) begin
                m_chan = 1'b1; m_k = 0;
            end
            if (fall && m_started) begin
                if (lf || lr) begin
                    m_dac = 1'b0;
                end else begin
                    if (m_k < 1000) m_k++;
                    word = m_chan ? m_act_r : m_act_l;
                    if (m_k >= 2 && m_k <= DATA_W + 1) begin
                        m_dac = word[DATA_W + 1 - m_k];
                        m_bit_new = 1'b1;
                    end else begin
                        m_dac = 1'b0;
                    end
                end
            end
            prev_bclk = b;
            prev_lrc  = l;
        end
    endtask

    task automatic half(input int n, input bit l, input int ph);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < ph; j++) begin
                if (i == 0 && j == 0 && inject_pending && !l) begin
                    src_q.push_back(inject_pair);
                    inject_pending = 1'b0;
                end
                step(1'b0, l);
            end
            for (int j = 0; j < ph; j++) step(1'b1, l);
        end
    endtask

    task automatic frame(input int nl, input int nr, input int ph);
        half(nl, 1'b0, ph);
        half(nr, 1'b1, ph);
    endtask

    task automatic do_reset();
        drv_rst_n = 1'b0;
        repeat (3) step(1'b1, 1'b0);
        drv_rst_n = 1'b1;
        step(1'b1, 1'b0);
    endtask

    initial begin
        model_reset();
        cap_l = '0; cap_r = '0;
        rst_n = 1'b0;

        // 1: pair loaded before first frame, rise after reset ignored
        do_reset();
        src_q.push_back(pair_t'({16'hA5C3, 16'h0F0F}));
        half(20, 1'b1, 2);
        frame(20, 20, 2);
        check_val("t1_left",  32'(cap_l), 32'h0000A5C3);
        check_val("t1_right", 32'(cap_r), 32'h00000F0F);

        // 2: starvation, counter counts up
        repeat (3) frame(20, 20, 2);
        check_val("t2_cnt",  32'(underrun_cnt), 32'd3);
        check_val("t2_left", 32'(cap_l), 32'd0);

        // 3: two pairs back to back with valid held
        src_q.push_back(pair_t'({16'h1234, 16'h5678}));
        src_q.push_back(pair_t'({16'h9ABC, 16'hDEF0}));
        half(20, 1'b1, 2);
        frame(20, 20, 2);
        check_val("t3_p1_left",  32'(cap_l), 32'h00001234);
        check_val("t3_p1_right", 32'(cap_r), 32'h00005678);
        frame(20, 20, 2);
        check_val("t3_p2_left",  32'(cap_l), 32'h00009ABC);
        check_val("t3_p2_right", 32'(cap_r), 32'h0000DEF0);

        // 4: valid first raised in the frame-start cycle
        inject_pair    = pair_t'({16'hC0DE, 16'h7E57});
        inject_pending = 1'b1;
        frame(20, 20, 2);
        check_val("t4_cnt",  32'(underrun_cnt), 32'd4);
        check_val("t4_zero", 32'(cap_l), 32'd0);
        frame(20, 20, 2);
        check_val("t4_left",  32'(cap_l), 32'h0000C0DE);
        check_val("t4_right", 32'(cap_r), 32'h00007E57);

        // 5: reset during left shift at bit 7 with a second pair buffered
        src_q.push_back(pair_t'({16'hA5C3, 16'h0F0F}));
        src_q.push_back(pair_t'({16'hA5C3, 16'h0F0F}));
        half(20, 1'b1, 2);
        half(11, 1'b0, 2);
        check_val("t5_bit7", 32'(dacdat), 32'd1);
        check_val("t5_full", 32'(sample_ready), 32'd0);
        drv_rst_n = 1'b0;
        step(1'b1, 1'b0);
        #1;
        check_val("t5_rst_dac",   32'(dacdat),       32'd0);
        check_val("t5_rst_ready", 32'(sample_ready), 32'd1);
        check_val("t5_rst_cnt",   32'(underrun_cnt), 32'd0);
        repeat (2) step(1'b1, 1'b0);
        drv_rst_n = 1'b1;
        step(1'b1, 1'b0);
        src_q.push_back(pair_t'({16'h3C3C, 16'hC3C3}));
        half(20, 1'b1, 2);
        frame(20, 20, 2);
        check_val("t5_left",  32'(cap_l), 32'h00003C3C);
        check_val("t5_right", 32'(cap_r), 32'h0000C3C3);
        check_val("t5_cnt",   32'(underrun_cnt), 32'd0);

        // 6: saturation of the underrun counter
        repeat (300) frame(20, 20, 1);
        check_val("t6_sat", 32'(underrun_cnt), 32'h000000FF);

        // random producer, random half lengths (some abort mid-word)
        rand_prod = 1'b1;
        repeat (40) frame($urandom_range(8, 31), $urandom_range(8, 31), $urandom_range(1, 2));
        rand_prod = 1'b0;
        step(1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
